// File: rtl/pipelined_cla_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_cla_adder_pkg
//  Description : Shared constants and helpers for the pipelined lookahead
//                adder: lookahead group width and the stage-count function.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipelined_cla_adder_pkg;

    // Every pipeline stage resolves one lookahead group of this many bits.
    localparam int GROUP_W = 4;

    // Number of pipeline stages (and the latency in cycles) for a given width.
    function automatic int calc_nstage(input int width);
        return width / GROUP_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_cla_adder_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_cla_adder_if
//  Description : Operand/result handshake bundle for the pipelined adder.
//                The master issues operations and consumes results; the
//                slave is the adder itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipelined_cla_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             C0;
    logic             SUB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] F;
    logic             COUT;
    logic             OV;
    logic             Z;

    modport master (
        output in_valid, A, B, C0, SUB, out_ready,
        input  in_ready, out_valid, F, COUT, OV, Z
    );

    modport slave (
        input  in_valid, A, B, C0, SUB, out_ready,
        output in_ready, out_valid, F, COUT, OV, Z
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_cla_adder_cla_group4.sv
`default_nettype none
// ============================================================================
//  Module      : cla_group4
//  Description : Combinational 4-bit carry-lookahead group. Produces the sum,
//                the group generate/propagate terms and the group carry-out.
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_group4 (
    input  wire  [3:0] a,
    input  wire  [3:0] b,
    input  wire        c,
    output logic [3:0] s,
    output logic       g_out,
    output logic       p_out,
    output logic       cout
);
    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [3:0] w_c;

    // Flattened lookahead: every internal carry depends only on g/p and c,
    // never on a neighbouring carry, so the group has no ripple path.
    always_comb begin
        w_g    = a & b;
        w_p    = a | b;
        w_c[0] = c;
        w_c[1] = w_g[0] | (w_p[0] & c);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & c);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & c);
        g_out  = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
        p_out  = &w_p;
        cout   = g_out | (p_out & c);
        s      = a ^ b ^ w_c;
    end
endmodule
`default_nettype wire

// File: rtl/pipelined_cla_adder.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_cla_adder
//  Description : Pipelined carry-lookahead adder/subtractor. One 4-bit
//                lookahead group is resolved per stage; the group carry and
//                the operands travel down the pipe with the partial sum.
//                The final stage registers F together with COUT/OV/Z.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_cla_adder
    import pipelined_cla_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input wire                   clk,
    input wire                   rst,
    pipelined_cla_adder_if.slave bus
);
    localparam int NSTAGE = calc_nstage(WIDTH);
    localparam int TOP    = NSTAGE - 1;

    // One pipeline slot: partial sum so far, carry into the next group and
    // the conditioned operands whose upper groups are still to be summed.
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] sum;
        logic             carry;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } stage_t;

    stage_t r_stg [NSTAGE];
    stage_t w_src [NSTAGE];
    logic   r_ov;
    logic   r_z;
    logic   w_advance;

    // The whole pipe moves in lock-step unless a held result blocks it.
    assign w_advance    = !r_stg[TOP].valid || bus.out_ready;
    assign bus.in_ready = w_advance;

    // Subtraction is A + ~B + ~C0, so C0 acts as a borrow-in.
    assign w_src[0] = '{valid: bus.in_valid,
                        sum:   '0,
                        carry: bus.SUB ? ~bus.C0 : bus.C0,
                        a:     bus.A,
                        b:     bus.SUB ? ~bus.B : bus.B};

    generate
        for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
            logic [GROUP_W-1:0] w_s;
            logic               w_cout;
            // Group G/P are only needed by a second lookahead level; here the
            // group carry is carried forward through the stage registers.
            logic               w_unused_g;
            logic               w_unused_p;
            stage_t             w_next;

            if (k > 0) begin : g_chain
                assign w_src[k] = r_stg[k-1];
            end

            cla_group4 u_group (
                .a     (w_src[k].a[GROUP_W*k +: GROUP_W]),
                .b     (w_src[k].b[GROUP_W*k +: GROUP_W]),
                .c     (w_src[k].carry),
                .s     (w_s),
                .g_out (w_unused_g),
                .p_out (w_unused_p),
                .cout  (w_cout)
            );

            // Merge this group's sum bits and carry into the travelling slot.
            always_comb begin
                w_next                               = w_src[k];
                w_next.sum[GROUP_W*k +: GROUP_W]     = w_s;
                w_next.carry                         = w_cout;
            end

            // Stage register: holds when stalled, bubbles advance like data.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_stg[k] <= '0;
                end else if (w_advance) begin
                    r_stg[k] <= w_next;
                end
            end

            if (k == TOP) begin : g_flags
                // Carry into the MSB is recovered as a^b^s of that bit,
                // so overflow needs no extra tap inside the group.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_ov <= 1'b0;
                        r_z  <= 1'b0;
                    end else if (w_advance) begin
                        r_ov <= w_next.a[WIDTH-1] ^ w_next.b[WIDTH-1]
                              ^ w_next.sum[WIDTH-1] ^ w_next.carry;
                        r_z  <= (w_next.sum == '0);
                    end
                end
            end
        end
    endgenerate

    assign bus.out_valid = r_stg[TOP].valid;
    assign bus.F         = r_stg[TOP].sum;
    assign bus.COUT      = r_stg[TOP].carry;
    assign bus.OV        = r_ov;
    assign bus.Z         = r_z;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_cla_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_cla_adder
//  Description : Self-checking bench for pipelined_cla_adder (WIDTH=16).
//                Accepted operations are modelled with integer arithmetic
//                and queued; a monitor pops and compares on each output
//                transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_cla_adder;
    localparam int WIDTH  = 16;
    localparam int NSTAGE = WIDTH / 4;

    typedef struct {
        logic [15:0] f;
        logic        cout;
        logic        ov;
        logic        z;
        int          issue;
        int          stalls;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    int   stalls = 0;
    bit   rand_done;
    exp_t sb[$];

    pipelined_cla_adder_if #(.WIDTH(WIDTH)) bus ();

    pipelined_cla_adder #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    // Reference: exact integer arithmetic on the operands.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic c0, input logic sub);
        exp_t e;
        int ua = int'(a);
        int ub = int'(b);
        int sa = int'($signed(a));
        int sb_ = int'($signed(b));
        int ci = int'(c0);
        int ru;
        int rs;
        if (!sub) begin
            ru     = ua + ub + ci;
            rs     = sa + sb_ + ci;
            e.cout = (ru > 65535);
        end else begin
            ru     = ua - ub - ci;
            rs     = sa - sb_ - ci;
            e.cout = (ru >= 0);
        end
        e.f      = ru[15:0];
        e.ov     = (rs > 32767) || (rs < -32768);
        e.z      = (e.f == 16'h0000);
        e.issue  = 0;
        e.stalls = 0;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor first (pops results), then capture (pushes new operations).
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && !bus.out_ready) stalls++;
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out: got F=0x%0h with no operation outstanding", bus.F);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("F", int'(bus.F), int'(e.f));
                    chk("COUT", int'(bus.COUT), int'(e.cout));
                    chk("OV", int'(bus.OV), int'(e.ov));
                    chk("Z", int'(bus.Z), int'(e.z));
                    if (e.stalls == stalls) chk("latency", cycle - e.issue, NSTAGE);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_t e;
                e        = model(bus.A, bus.B, bus.C0, bus.SUB);
                e.issue  = cycle;
                e.stalls = stalls;
                sb.push_back(e);
            end
        end
    end

    // Present one operation and hold it until accepted; then scramble inputs.
    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic c0, input logic sub);
        int wait_cnt = 0;
        bus.A = a; bus.B = b; bus.C0 = c0; bus.SUB = sub;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && wait_cnt < 200) begin
            wait_cnt++;
            @(negedge clk);
        end
        if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.A   = 16'($urandom);
        bus.B   = 16'($urandom);
        bus.C0  = 1'($urandom);
        bus.SUB = 1'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.A = '0; bus.B = '0; bus.C0 = 1'b0; bus.SUB = 1'b0;

        // Reset state
        #12;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_F", int'(bus.F), 0);
        chk("rst_flags", int'({bus.COUT, bus.OV, bus.Z}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        @(posedge clk); #1;

        // Directed adds/subs, back to back
        issue(16'h00FF, 16'h0001, 1'b0, 1'b0);
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        issue(16'h0005, 16'h0007, 1'b0, 1'b1);
        issue(16'h8000, 16'h0001, 1'b0, 1'b1);
        issue(16'h1234, 16'h1234, 1'b1, 1'b1);
        drain();

        // Stream with a 3-cycle output stall on the first result
        bus.out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) issue(16'h1000, 16'(i), 1'b0, 1'b0);
            end
            begin
                int n = 0;
                @(negedge clk);
                while (!bus.out_valid && n < 50) begin
                    n++;
                    @(negedge clk);
                end
                for (int h = 0; h < 3; h++) begin
                    chk("hold_in_ready", int'(bus.in_ready), 0);
                    chk("hold_F", int'(bus.F), 16'h1000);
                    if (h < 2) @(negedge clk);
                end
                @(posedge clk); #1;
                bus.out_ready = 1'b1;
                for (int g = 0; g < 6; g++) begin
                    @(negedge clk);
                    chk("stream_no_gap", int'(bus.out_valid), 1);
                end
            end
        join
        drain();

        // Issue on cycles 0, 2, 3 relative: latency check pins output cycles
        issue(16'h0010, 16'h0020, 1'b0, 1'b0);
        idle(1);
        issue(16'h0100, 16'h0200, 1'b1, 1'b0);
        issue(16'hF000, 16'h1000, 1'b0, 1'b0);
        drain();

        // Random traffic with random back-pressure
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    idle($urandom_range(0, 2));
                    issue(pick(), pick(), 1'($urandom), 1'($urandom));
                end
                rand_done = 1'b1;
            end
            begin
                int n = 0;
                while (!rand_done && n < 2000) begin
                    @(posedge clk); #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    n++;
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three operations in flight
        issue(16'h1111, 16'h2222, 1'b0, 1'b0);
        issue(16'h3333, 16'h4444, 1'b0, 1'b0);
        issue(16'h5555, 16'h6666, 1'b0, 1'b0);
        rst = 1'b1;
        sb.delete();
        #1;
        chk("mid_rst_out_valid", int'(bus.out_valid), 0);
        chk("mid_rst_F", int'(bus.F), 0);
        chk("mid_rst_flags", int'({bus.COUT, bus.OV, bus.Z}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        issue(16'h0001, 16'h0001, 1'b0, 1'b0);
        drain();
        idle(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
`default_nettype wire
